// File: rtl/parallel_axis_playback.sv
// Preloaded beat buffer replayed as an AXI4-Stream master.
// Loaded through wr_* while idle; start replays frames once or in a loop.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   wr_en/addr/data beat write into the buffer (accepted only when idle)
//   start, loop     playback pulse; loop sampled with start
//   abort           level; stop at the next frame boundary
//   m_axis_*        stream master (tuser = frame index)
//   busy, done      activity level and end-of-playback pulse
//   wr_drop         sticky flag for writes attempted while busy
module parallel_axis_playback #(
  parameter int SAMP_PER_CLK = 2,
  parameter int SAMP_W = 32,
  parameter int FRAME_LEN = 64,
  parameter int FRAMES = 1,
  localparam int DEPTH = FRAMES * FRAME_LEN / SAMP_PER_CLK,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int DW = SAMP_PER_CLK * SAMP_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          loop,
  input  logic          abort,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic [FW-1:0] m_axis_tuser,
  output logic          busy,
  output logic          done,
  output logic          wr_drop
);

  localparam int BPF = FRAME_LEN / SAMP_PER_CLK;
  localparam int BW = (BPF > 1) ? $clog2(BPF) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BPF - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PLAY,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [FW-1:0] user;
  } beat_t;

  state_t state, state_nxt;

  logic [DW-1:0] mem [DEPTH];

  beat_t out_q, pf_q, rd_beat;
  logic out_v, pf_v;
  logic loop_q;

  logic [AW-1:0] rd_ptr;
  logic [BW-1:0] beat_idx;
  logic [FW-1:0] frame_idx;

  logic reading, start_ok, hs, cut;
  logic room, issue, at_end, empty_nxt;

  always_comb begin
    reading  = (state == FILL) || (state == PLAY);
    start_ok = (state == IDLE) && start;
    hs       = out_v && m_axis_tready;
    // tlast handshake with abort: frame done, drop what follows
    cut      = hs && out_q.last && abort;
    // pf_v implies out_v, so the skid is full only when pf_v
    room     = !(pf_v && !hs);
    issue    = reading && !cut && room;
    at_end   = (rd_ptr == LAST_PTR);
    empty_nxt = cut ||
      (!pf_v && (!out_v || hs) && !issue);
  end

  always_comb begin
    rd_beat.data = mem[rd_ptr];
    rd_beat.last = (beat_idx == LAST_BEAT);
    rd_beat.user = frame_idx;
  end

  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE))
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = FILL;
      end
      FILL, PLAY: begin
        if (cut)
          state_nxt = DRAIN;
        else if (issue && at_end && !loop_q)
          state_nxt = DRAIN;
        else if ((state == FILL) && out_v)
          state_nxt = PLAY;
      end
      DRAIN: begin
        if (empty_nxt)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid = out_v;
    m_axis_tdata  = out_q.data;
    m_axis_tlast  = out_v && out_q.last;
    m_axis_tuser  = out_q.user;
    busy          = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      wr_drop <= 1'b0;
      loop_q  <= 1'b0;
    end else begin
      done <= (state == DRAIN) && empty_nxt;
      if (start_ok) begin
        wr_drop <= 1'b0;
        loop_q  <= loop;
      end else if (wr_en && (state != IDLE)) begin
        wr_drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      beat_idx  <= '0;
      frame_idx <= '0;
    end else if (start_ok) begin
      rd_ptr    <= '0;
      beat_idx  <= '0;
      frame_idx <= '0;
    end else if (issue) begin
      if (at_end) begin
        rd_ptr    <= '0;
        beat_idx  <= '0;
        frame_idx <= '0;
      end else begin
        rd_ptr <= rd_ptr + 1'b1;
        if (beat_idx == LAST_BEAT) begin
          beat_idx  <= '0;
          frame_idx <= frame_idx + 1'b1;
        end else begin
          beat_idx <= beat_idx + 1'b1;
        end
      end
    end
  end

  // Two-slot skid: out_q drives the bus, pf_q holds one prefetch.
  // Read data lands straight into whichever slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      pf_q  <= '0;
      out_v <= 1'b0;
      pf_v  <= 1'b0;
    end else if (cut) begin
      out_v <= 1'b0;
      pf_v  <= 1'b0;
    end else if (hs) begin
      if (pf_v) begin
        out_q <= pf_q;
        if (issue)
          pf_q <= rd_beat;
        else
          pf_v <= 1'b0;
      end else if (issue) begin
        out_q <= rd_beat;
      end else begin
        out_v <= 1'b0;
      end
    end else if (issue) begin
      if (!out_v) begin
        out_q <= rd_beat;
        out_v <= 1'b1;
      end else begin
        pf_q <= rd_beat;
        pf_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parallel_axis_playback.sv
// Bench for parallel_axis_playback: scenario table plus
// reset and write-drop sequences against a stream model.
module tb_parallel_axis_playback;

  localparam int FR = 2;
  localparam int DEPTH = 64;
  localparam int BPF = 32;
  localparam int AW = 6;
  localparam int FW = 1;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          loop = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
  logic [FW-1:0] tuser;
  logic          busy;
  logic          done;
  logic          wr_drop;

  parallel_axis_playback #(
    .SAMP_PER_CLK(2),
    .SAMP_W(32),
    .FRAME_LEN(64),
    .FRAMES(FR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start(start),
    .loop(loop),
    .abort(abort),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast(tlast),
    .m_axis_tuser(tuser),
    .busy(busy),
    .done(done),
    .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lp;
    int pct;
    int abort_at;
    int wr_at;
    int exp_beats;
  } scn_t;

  scn_t tbl[6];
  logic [DW-1:0] model [DEPTH];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (ok)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
  endtask

  task automatic run_scn(input scn_t s);
    int cyc, nhs, idx;
    int first_v, first_hs, last_hs, done_cyc;
    bit stall, busy_ok, el;
    logic [DW-1:0] pd;
    logic pl;
    logic [FW-1:0] pu, eu;
    nhs = 0; first_v = -1; first_hs = -1;
    last_hs = -1; done_cyc = -1;
    stall = 0; busy_ok = 1;
    pd = '0; pl = 0; pu = '0;
    loop = s.lp;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    loop = 1'b0;
    cyc = 0;
    chk(wr_drop == 1'b0, "wr_drop_clr", 64'(wr_drop), 0);
    chk(!tvalid && busy, "fill_cycle",
        64'({tvalid, busy}), 64'h1);
    while (cyc < 4000) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!busy) busy_ok = 0;
      if (tvalid && first_v < 0) first_v = cyc;
      if (stall)
        chk(tvalid && tdata == pd && tlast == pl && tuser == pu,
            "stall_hold", tdata, pd);
      if (s.wr_at >= 0 && cyc == s.wr_at + 1)
        chk(wr_drop == 1'b1, "wr_drop_set", 64'(wr_drop), 1);
      if (cyc == s.wr_at) begin
        wr_en = 1'b1;
        wr_addr = AW'(5);
        wr_data = ~model[5];
      end else begin
        wr_en = 1'b0;
      end
      abort = (s.abort_at >= 0) && (nhs >= s.abort_at);
      tready = (int'($urandom_range(0, 99)) < s.pct);
      stall = tvalid && !tready;
      pd = tdata; pl = tlast; pu = tuser;
      if (tvalid && tready) begin
        idx = nhs % DEPTH;
        el = ((idx % BPF) == BPF - 1);
        eu = FW'(idx / BPF);
        chk(tdata == model[idx] && tlast == el && tuser == eu,
            "beat", tdata, model[idx]);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        nhs++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    wr_en = 1'b0;
    abort = 1'b0;
    tready = 1'b0;
    chk(done_cyc >= 0, "done_seen", 64'(done_cyc), 0);
    chk(!busy, "busy_fall", 64'(busy), 0);
    chk(nhs == s.exp_beats, "beat_count",
        64'(nhs), 64'(s.exp_beats));
    chk(first_v == 1, "first_valid_lat", 64'(first_v), 1);
    chk(busy_ok, "busy_held", 64'(busy_ok), 1);
    if (s.abort_at < 0)
      chk(done_cyc == last_hs + 1, "done_lat",
          64'(done_cyc), 64'(last_hs + 1));
    if (s.pct == 100)
      chk(last_hs - first_hs + 1 == nhs, "no_bubble",
          64'(last_hs - first_hs + 1), 64'(nhs));
    @(posedge clk); #1;
    chk(!done, "done_pulse", 64'(done), 0);
  endtask

  initial begin
    int nhs, cyc;
    tbl[0] = '{lp: 0, pct: 100, abort_at: -1, wr_at: -1, exp_beats: 64};
    tbl[1] = '{lp: 0, pct: 50,  abort_at: -1, wr_at: -1, exp_beats: 64};
    tbl[2] = '{lp: 1, pct: 100, abort_at: 10, wr_at: -1, exp_beats: 32};
    tbl[3] = '{lp: 1, pct: 100, abort_at: 100, wr_at: -1, exp_beats: 128};
    tbl[4] = '{lp: 0, pct: 70,  abort_at: -1, wr_at: 3, exp_beats: 64};
    tbl[5] = '{lp: 1, pct: 50,  abort_at: 40, wr_at: -1, exp_beats: 64};

    for (int i = 0; i < DEPTH; i++)
      model[i] = {$urandom, $urandom};

    #2;
    chk(!tvalid && !tlast && tuser == '0 && tdata == '0 &&
        !busy && !done && !wr_drop, "reset_state",
        64'({tvalid, tlast, busy, done, wr_drop}), 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1;
      wr_addr = AW'(i);
      wr_data = model[i];
      @(posedge clk); #1;
    end
    wr_en = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_scn(tbl[i]);
      if (tbl[i].wr_at >= 0)
        chk(wr_drop == 1'b1, "wr_drop_sticky", 64'(wr_drop), 1);
    end

    loop = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tready = 1'b1;
    nhs = 0;
    cyc = 0;
    while (nhs < 7 && cyc < 100) begin
      if (tvalid) nhs++;
      @(posedge clk); #1;
      cyc++;
    end
    tready = 1'b0;
    chk(nhs == 7, "pre_reset_beats", 64'(nhs), 7);
    @(posedge clk); #1;
    chk(tvalid && busy && tdata == model[7], "pre_reset_stall",
        tdata, model[7]);
    #3;
    rst_n = 1'b0;
    #1;
    chk(!tvalid && !busy && !tlast && !done, "async_reset",
        64'({tvalid, busy, tlast, done}), 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_scn(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
